// File: rtl/accumulate_ctrl.sv
// Pushbutton sequencer for the board accumulator: turns step/clear
// presses into range-checked acc_en / acc_clr strobes and counts ops.
module accumulate_ctrl_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  logic [1:0] sync;
  logic       hist;

  // Reset to "released" so no press appears when reset lifts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      hist <= 1'b1;
    end else begin
      sync <= {sync[0], btn_n};
      hist <= sync[1];
    end
  end

  assign level = sync[1];
  assign press = ~sync[1] & hist;

endmodule

module accumulate_ctrl #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 10,
  parameter int MAX_OPS   = 8
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 step_n,
  input  logic                 clear_n,
  input  logic                 sub,
  input  logic [WIDTH-1:0]     data,
  input  logic [ACC_WIDTH-1:0] acc_q,
  output logic [WIDTH-1:0]     operand,
  output logic                 acc_en,
  output logic                 acc_sub,
  output logic                 acc_clr,
  output logic [3:0]           op_count,
  output logic                 ovf,
  output logic                 done,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    APPLY,
    CLEAR,
    WAIT_REL,
    HALT
  } state_t;

  state_t state;

  logic step_lvl;
  logic step_press;
  logic clr_lvl;
  logic clr_press;
  logic released;
  logic pend_clr;

  logic [ACC_WIDTH-1:0] op_ext;
  logic [ACC_WIDTH:0]   sum;
  logic                 range_err;
  logic [3:0]           next_count;

  accumulate_ctrl_sync u_step (
    .clk   (Clock),
    .rst_n (Resetn),
    .btn_n (step_n),
    .level (step_lvl),
    .press (step_press)
  );

  accumulate_ctrl_sync u_clr (
    .clk   (Clock),
    .rst_n (Resetn),
    .btn_n (clear_n),
    .level (clr_lvl),
    .press (clr_press)
  );

  assign released   = step_lvl & clr_lvl;
  assign op_ext     = ACC_WIDTH'(operand);
  // Carry out of the widened sum means the add exceeds 2^ACC_WIDTH-1
  assign sum        = {1'b0, acc_q} + {1'b0, op_ext};
  assign range_err  = sub ? (op_ext > acc_q) : sum[ACC_WIDTH];
  assign next_count = op_count + 4'd1;
  assign busy       = (state != IDLE);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      operand  <= '0;
      acc_en   <= 1'b0;
      acc_sub  <= 1'b0;
      acc_clr  <= 1'b0;
      op_count <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
      pend_clr <= 1'b0;
    end else begin
      acc_en  <= 1'b0;
      acc_clr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clr_press) begin
            state   <= CLEAR;
            acc_clr <= 1'b1;
          end else if (step_press && !done) begin
            operand <= data;
            state   <= CHECK;
          end
        end
        CHECK: begin
          acc_sub <= sub;
          if (clr_press) pend_clr <= 1'b1;
          if (range_err) begin
            ovf   <= 1'b1;
            state <= HALT;
          end else begin
            acc_en <= 1'b1;
            state  <= APPLY;
          end
        end
        APPLY: begin
          if (clr_press) pend_clr <= 1'b1;
          op_count <= next_count;
          done     <= (next_count == 4'(MAX_OPS));
          state    <= WAIT_REL;
        end
        CLEAR: begin
          op_count <= '0;
          ovf      <= 1'b0;
          done     <= 1'b0;
          pend_clr <= 1'b0;
          state    <= WAIT_REL;
        end
        WAIT_REL: begin
          if (released) begin
            if (pend_clr) begin
              acc_clr <= 1'b1;
              state   <= CLEAR;
            end else begin
              state <= IDLE;
            end
          end else if (clr_press) begin
            pend_clr <= 1'b1;
          end
        end
        HALT: begin
          if (clr_press || pend_clr) begin
            acc_clr <= 1'b1;
            state   <= CLEAR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
